// File: rtl/otg_hpi_bus_sequencer.sv
// Sequences one-shot host read/write requests into timed CY7C67200 HPI bus cycles.
// Each access runs SETUP, STROBE, HOLD and RECOVER; every bus-facing output is registered.
module otg_hpi_bus_sequencer #(
   parameter int SETUP_CYC    = 2,
   parameter int STROBE_CYC   = 4,
   parameter int HOLD_CYC     = 2,
   parameter int RECOVERY_CYC = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_address,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [15:0] req_writedata,
   output logic        req_waitrequest,
   output logic [15:0] rsp_readdata,
   output logic        rsp_valid,
   output logic [1:0]  otg_addr,
   output logic        otg_cs_n,
   output logic        otg_rd_n,
   output logic        otg_wr_n,
   output logic [15:0] otg_data_out,
   output logic        otg_data_oe,
   input  logic [15:0] otg_data_in
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETUP   = 3'd1;
   localparam logic [2:0] ST_STROBE  = 3'd2;
   localparam logic [2:0] ST_HOLD    = 3'd3;
   localparam logic [2:0] ST_RECOVER = 3'd4;

   generate
      if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
          HOLD_CYC < 1 || HOLD_CYC > 15 || RECOVERY_CYC < 1 || RECOVERY_CYC > 15) begin : g_bad_param
         $error("otg_hpi_bus_sequencer: cycle counts must be within 1..15");
      end
   endgenerate

   localparam logic [3:0] SETUP_LD    = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD   = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD     = 4'(HOLD_CYC - 1);
   localparam logic [3:0] RECOVERY_LD = 4'(RECOVERY_CYC - 1);

   logic [2:0] state_reg, state_next;
   logic [3:0] cnt_reg, cnt_next;
   logic       is_write_reg, is_write_next;
   logic       accept;
   logic       in_access_next;
   logic       capture;

   assign req_waitrequest = (state_reg != ST_IDLE);
   assign accept          = (state_reg == ST_IDLE) && (req_read || req_write);
   assign capture         = (state_reg == ST_STROBE) && (cnt_reg == 4'd0) && !is_write_reg;

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      is_write_next = is_write_reg;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               state_next    = ST_SETUP;
               cnt_next      = SETUP_LD;
               // A simultaneous read and write resolves to the write.
               is_write_next = req_write;
            end
         end
         ST_SETUP: begin
            if (cnt_reg == 4'd0) begin
               state_next = ST_STROBE;
               cnt_next   = STROBE_LD;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         ST_STROBE: begin
            if (cnt_reg == 4'd0) begin
               state_next = ST_HOLD;
               cnt_next   = HOLD_LD;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_reg == 4'd0) begin
               state_next = ST_RECOVER;
               cnt_next   = RECOVERY_LD;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         ST_RECOVER: begin
            if (cnt_reg == 4'd0) begin
               state_next = ST_IDLE;
               cnt_next   = 4'd0;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   // Pins are decoded from the next state so they change on the same edge as the FSM.
   assign in_access_next = (state_next == ST_SETUP) || (state_next == ST_STROBE) ||
                           (state_next == ST_HOLD);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= 4'd0;
         is_write_reg <= 1'b0;
         otg_addr     <= 2'd0;
         otg_data_out <= 16'h0000;
         otg_cs_n     <= 1'b1;
         otg_rd_n     <= 1'b1;
         otg_wr_n     <= 1'b1;
         otg_data_oe  <= 1'b0;
         rsp_readdata <= 16'h0000;
         rsp_valid    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         is_write_reg <= is_write_next;
         if (accept) begin
            otg_addr     <= req_address;
            otg_data_out <= req_writedata;
         end
         otg_cs_n    <= !in_access_next;
         otg_wr_n    <= !((state_next == ST_STROBE) && is_write_next);
         otg_rd_n    <= !((state_next == ST_STROBE) && !is_write_next);
         otg_data_oe <= in_access_next && is_write_next;
         rsp_valid   <= capture;
         if (capture) begin
            rsp_readdata <= otg_data_in;
         end
      end
   end

endmodule

// File: tb/tb_otg_hpi_bus_sequencer.sv
// Scoreboard bench for otg_hpi_bus_sequencer: default timing and all-ones timing instances,
// each with directed and random accesses checked by a pin-level bus monitor.
module tb_otg_hpi_bus_sequencer;

   typedef struct packed {
      bit          wr;
      logic [1:0]  addr;
      logic [15:0] data;
   } acc_t;

   logic clk = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   task automatic chk_eq(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL i%0d %s: got %0h expected %0h", id, name, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int ID = gi;
      localparam int S  = (gi == 0) ? 2 : 1;
      localparam int T  = (gi == 0) ? 4 : 1;
      localparam int H  = (gi == 0) ? 2 : 1;
      localparam int R  = (gi == 0) ? 2 : 1;

      logic        reset;
      logic [1:0]  req_address;
      logic        req_read, req_write;
      logic [15:0] req_writedata;
      logic        req_waitrequest;
      logic [15:0] rsp_readdata;
      logic        rsp_valid;
      logic [1:0]  otg_addr;
      logic        otg_cs_n, otg_rd_n, otg_wr_n;
      logic [15:0] otg_data_out;
      logic        otg_data_oe;
      logic [15:0] otg_data_in;
      logic [15:0] bus_val;
      bit          done = 1'b0;

      acc_t        exp_q[$];
      logic [15:0] rsp_q[$];

      int          cs_cnt, strb_first, rd_lo, wr_lo, hi_cnt, wait_run, viol, rd_low_cnt;
      bit          active, oe_all, oe_any, data_chg, addr_chg, prev_rd_n, prev_wait, exp_v;
      logic [15:0] first_data, last_rd, v;
      logic [1:0]  first_addr;
      acc_t        e;

      // The chip only presents valid read data late in the strobe (after T low cycles).
      assign otg_data_in = (!otg_rd_n && rd_low_cnt == T) ? bus_val : ~bus_val;

      otg_hpi_bus_sequencer #(
         .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .RECOVERY_CYC(R)
      ) dut (
         .clk(clk), .reset(reset),
         .req_address(req_address), .req_read(req_read), .req_write(req_write),
         .req_writedata(req_writedata), .req_waitrequest(req_waitrequest),
         .rsp_readdata(rsp_readdata), .rsp_valid(rsp_valid),
         .otg_addr(otg_addr), .otg_cs_n(otg_cs_n), .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n),
         .otg_data_out(otg_data_out), .otg_data_oe(otg_data_oe), .otg_data_in(otg_data_in)
      );

      task automatic do_access(input bit wr, input bit rd, input logic [1:0] a,
                               input logic [15:0] d, input logic [15:0] bv);
         bit ok = 1'b0;
         req_write = wr; req_read = rd; req_address = a; req_writedata = d;
         for (int i = 0; i < 200; i++) begin
            if (!req_waitrequest) begin
               ok = 1'b1;
               break;
            end
            @(posedge clk); #1;
         end
         if (!ok) begin
            chk_eq(ID, "accept_timeout", 1, 0);
         end else if (wr) begin
            exp_q.push_back('{1'b1, a, d});
         end else begin
            bus_val = bv;
            exp_q.push_back('{1'b0, a, bv});
            rsp_q.push_back(bv);
         end
         @(posedge clk); #1;
         req_write = 1'b0; req_read = 1'b0;
      endtask

      task automatic abort_write();
         for (int i = 0; i < 200 && req_waitrequest; i++) begin
            @(posedge clk); #1;
         end
         req_write = 1'b1; req_address = 2'd1; req_writedata = 16'h5A5A;
         @(posedge clk); #1;
         req_write = 1'b0;
         repeat (S + ((T >= 2) ? 1 : 0)) @(posedge clk);
         #1;
         chk_eq(ID, "abort_wr_n_low_before", otg_wr_n, 0);
         reset = 1'b1;
         @(posedge clk); #1;
         chk_eq(ID, "abort_wr_n", otg_wr_n, 1);
         chk_eq(ID, "abort_cs_n", otg_cs_n, 1);
         chk_eq(ID, "abort_oe", otg_data_oe, 0);
         chk_eq(ID, "abort_waitrequest", req_waitrequest, 0);
         chk_eq(ID, "abort_readdata", rsp_readdata, 0);
         reset = 1'b0;
      endtask

      initial begin : stim
         reset = 1'b1; req_read = 1'b0; req_write = 1'b0;
         req_address = 2'd0; req_writedata = 16'h0000; bus_val = 16'h0000;
         repeat (3) @(posedge clk);
         #1;
         chk_eq(ID, "rst_cs_n", otg_cs_n, 1);
         chk_eq(ID, "rst_rd_n", otg_rd_n, 1);
         chk_eq(ID, "rst_wr_n", otg_wr_n, 1);
         chk_eq(ID, "rst_oe", otg_data_oe, 0);
         chk_eq(ID, "rst_waitrequest", req_waitrequest, 0);
         chk_eq(ID, "rst_readdata", rsp_readdata, 0);
         chk_eq(ID, "rst_valid", rsp_valid, 0);
         reset = 1'b0;
         do_access(1'b1, 1'b0, 2'd2, 16'h1234, 16'h0000);
         do_access(1'b0, 1'b1, 2'd3, 16'h0000, 16'hBEEF);
         do_access(1'b1, 1'b0, 2'd0, 16'h0001, 16'h0000);
         do_access(1'b0, 1'b1, 2'd1, 16'h0000, 16'(($urandom)));
         do_access(1'b1, 1'b1, 2'd2, 16'hA5A5, 16'h1111);
         abort_write();
         do_access(1'b0, 1'b1, 2'd0, 16'h0000, 16'h00FF);
         for (int n = 0; n < 30; n++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            do_access(kind != 1, kind != 0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
         repeat (30) @(posedge clk);
         #1;
         chk_eq(ID, "accesses_outstanding", exp_q.size(), 0);
         chk_eq(ID, "responses_outstanding", rsp_q.size(), 0);
         chk_eq(ID, "strobe_invariant_violations", viol, 0);
         done = 1'b1;
      end

      always @(negedge clk) begin
         if (reset) begin
            active = 1'b0; hi_cnt = 100; wait_run = 0; prev_wait = 1'b0;
            prev_rd_n = 1'b1; last_rd = 16'h0000; rd_low_cnt = 0;
            rsp_q.delete();
         end else begin
            if (!otg_rd_n && !otg_wr_n) viol++;
            if ((!otg_rd_n || !otg_wr_n) && otg_cs_n) viol++;
            rd_low_cnt = otg_rd_n ? 0 : rd_low_cnt + 1;

            if (req_waitrequest) begin
               wait_run++;
            end else if (prev_wait) begin
               chk_eq(ID, "busy_cycles", wait_run, S + T + H + R);
               wait_run = 0;
            end
            prev_wait = req_waitrequest;

            exp_v = !prev_rd_n && otg_rd_n;
            if (rsp_valid || exp_v) begin
               chk_eq(ID, "rsp_valid_timing", rsp_valid, exp_v);
               if (rsp_valid) begin
                  if (rsp_q.size() == 0) begin
                     chk_eq(ID, "rsp_unexpected", 1, 0);
                  end else begin
                     v = rsp_q.pop_front();
                     chk_eq(ID, "rsp_readdata", rsp_readdata, v);
                     last_rd = v;
                  end
               end
            end
            prev_rd_n = otg_rd_n;

            if (!otg_cs_n) begin
               if (!active) begin
                  active = 1'b1;
                  chk_eq(ID, "cs_high_gap_ok", hi_cnt > R, 1);
                  cs_cnt = 0; strb_first = -1; rd_lo = 0; wr_lo = 0;
                  oe_all = 1'b1; oe_any = 1'b0; data_chg = 1'b0; addr_chg = 1'b0;
                  first_data = otg_data_out; first_addr = otg_addr;
               end
               if ((!otg_rd_n || !otg_wr_n) && strb_first < 0) strb_first = cs_cnt;
               if (!otg_rd_n) rd_lo++;
               if (!otg_wr_n) wr_lo++;
               oe_all = oe_all && otg_data_oe;
               oe_any = oe_any || otg_data_oe;
               if (otg_data_out !== first_data) data_chg = 1'b1;
               if (otg_addr !== first_addr) addr_chg = 1'b1;
               cs_cnt++;
            end else if (active) begin
               active = 1'b0;
               hi_cnt = 1;
               if (exp_q.size() == 0) begin
                  chk_eq(ID, "unexpected_access", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk_eq(ID, "cs_low_cycles", cs_cnt, S + T + H);
                  chk_eq(ID, "strobe_offset", strb_first, S);
                  chk_eq(ID, "wr_n_low_cycles", wr_lo, e.wr ? T : 0);
                  chk_eq(ID, "rd_n_low_cycles", rd_lo, e.wr ? 0 : T);
                  chk_eq(ID, "addr", {addr_chg, first_addr}, {1'b0, e.addr});
                  if (e.wr) begin
                     chk_eq(ID, "write_oe_all", oe_all, 1);
                     chk_eq(ID, "write_data", {data_chg, first_data}, {1'b0, e.data});
                  end else begin
                     chk_eq(ID, "read_oe_any", oe_any, 0);
                  end
                  chk_eq(ID, "readdata_held", rsp_readdata, last_rd);
                  $display("i%0d %s addr=%0d data=%04h cs_low=%0d", ID, e.wr ? "write" : "read ",
                           e.addr, e.data, cs_cnt);
               end
            end else begin
               hi_cnt++;
            end
         end
      end
   end

   initial begin : finisher
      for (int c = 0; c < 60000; c++) begin
         @(posedge clk);
         if (g_inst[0].done && g_inst[1].done) break;
      end
      if (!(g_inst[0].done && g_inst[1].done)) begin
         checks++;
         errors++;
         $display("FAIL global run_timeout: got not-done expected done");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
